// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package data_mem_resp_pkg;

    localparam int unsigned WordWidth         = 16;
    localparam int unsigned DefaultDepth      = 256;
    localparam int unsigned DefaultWaitStates = 2;
    localparam int unsigned CntWidth          = 3;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Full-width compare so upper address bits can never alias into the array.
    function automatic logic addr_in_range(input logic [WordWidth-1:0] addr,
                                           input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bundle between the MEM stage (master) and the responder (slave).
interface data_mem_resp_if;
    import data_mem_resp_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [WordWidth-1:0] req_addr;
    logic [WordWidth-1:0] req_wdata;
    logic                 resp_valid;
    logic [WordWidth-1:0] resp_rdata;
    logic                 resp_err;
    logic                 busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/dm_array.sv
// Single-port synchronous RAM with registered read data; contents survive reset.
module dm_array #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: accept, wait WAIT_STATES cycles, commit, pulse resp_valid.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = DefaultDepth,
    parameter int unsigned WAIT_STATES = DefaultWaitStates
) (
    input logic             clk,
    input logic             rst_n,
    data_mem_resp_if.slave  bus
);

    localparam int unsigned AddrWidth = $clog2(DEPTH);

    state_e               state_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 write_q;
    logic [WordWidth-1:0] addr_q;
    logic [WordWidth-1:0] wdata_q;
    logic                 req_ready_q;
    logic                 busy_q;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic                 rdata_sel_q;

    logic                 accept;
    logic                 commit;
    logic                 c_write;
    logic                 c_in_range;
    logic [WordWidth-1:0] c_addr;
    logic [WordWidth-1:0] c_wdata;
    logic                 ram_we;
    logic                 ram_re;
    logic [WordWidth-1:0] ram_rdata;

    // With no wait states the commit happens on the accept edge, straight from the bus.
    always_comb begin
        accept = bus.req_valid && req_ready_q;
        if (WAIT_STATES == 0) begin
            commit  = accept;
            c_write = bus.req_write;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
        end else begin
            commit  = (state_q == StWait) && (cnt_q == CntWidth'(1));
            c_write = write_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end
        c_in_range = addr_in_range(c_addr, DEPTH);
        ram_we     = commit && c_write && c_in_range;
        ram_re     = commit && !c_write && c_in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_sel_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (WAIT_STATES == 0) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            req_ready_q  <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q     <= StWait;
                            cnt_q       <= CntWidth'(WAIT_STATES);
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end else begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntWidth'(1)) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
            // Response status only changes at commit, so it holds after the pulse.
            if (commit) begin
                resp_err_q  <= !c_in_range;
                rdata_sel_q <= !c_write && c_in_range;
            end
        end
    end

    dm_array #(
        .DEPTH      (DEPTH),
        .WIDTH      (WordWidth),
        .ADDR_WIDTH (AddrWidth)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (c_addr[AddrWidth-1:0]),
        .wdata (c_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.busy       = busy_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_sel_q ? ram_rdata : '0;

endmodule
